// File: rtl/wb_demux_pkg.sv
// Shared types and defaults for the write-back 1-to-2 demultiplexer.
package wb_demux_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_ADDR_W = 5;
    localparam int unsigned CNT_W      = 16;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    localparam logic BR_REGFILE = 1'b0;
    localparam logic BR_PERIPH  = 1'b1;

endpackage

// File: rtl/wb_demux_slot.sv
// One-entry holding slot with valid/ready handshake for one demux branch.
// Optional saturating handoff counter under WB_DEMUX_STATS_EN.
module wb_demux_slot
    import wb_demux_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic              can_load,
    output logic              valid,
    input  logic              ready,
    output logic [ADDR_W-1:0] addr,
`ifdef WB_DEMUX_STATS_EN
    output logic [CNT_W-1:0]  count,
`endif
    output logic [DATA_W-1:0] data
);

    slot_state_e       state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              drain;

    assign drain    = (state_q == SLOT_FULL) && ready;
    // A full slot can be reloaded in the same cycle it drains.
    assign can_load = (state_q == SLOT_EMPTY) || ready;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SLOT_EMPTY: if (load) state_d = SLOT_FULL;
            SLOT_FULL:  if (drain && !load) state_d = SLOT_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SLOT_EMPTY;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                addr_q <= load_addr;
                data_q <= load_data;
            end
        end
    end

    assign valid = (state_q == SLOT_FULL);
    assign addr  = addr_q;
    assign data  = data_q;

`ifdef WB_DEMUX_STATS_EN
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (drain && (count_q != {CNT_W{1'b1}})) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;
`endif

endmodule

// File: rtl/wb_demux_1_2.sv
// Registered 1-to-2 write-back demux: branch 0 = register file, branch 1 = peripheral.
// Define WB_DEMUX_STATS_EN to add per-branch handoff counters count0/count1.
module wb_demux_1_2
    import wb_demux_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_select,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    output logic              out0_valid,
    input  logic              out0_ready,
    output logic [ADDR_W-1:0] out0_addr,
    output logic [DATA_W-1:0] out0_data,
`ifdef WB_DEMUX_STATS_EN
    output logic [15:0]       count0,
    output logic [15:0]       count1,
`endif
    output logic              out1_valid,
    input  logic              out1_ready,
    output logic [ADDR_W-1:0] out1_addr,
    output logic [DATA_W-1:0] out1_data
);

    logic can_load0, can_load1;
    logic drop, in_fire, load0, load1;

    // Writes to register 0 are accepted and discarded without touching slot 0.
    assign drop = (in_select == BR_REGFILE) && (in_addr == '0);

    always_comb begin
        in_ready = 1'b0;
        if (drop) begin
            in_ready = 1'b1;
        end else if (in_select == BR_PERIPH) begin
            in_ready = can_load1;
        end else begin
            in_ready = can_load0;
        end
    end

    assign in_fire = in_valid && in_ready;
    assign load0   = in_fire && (in_select == BR_REGFILE) && !drop;
    assign load1   = in_fire && (in_select == BR_PERIPH);

    wb_demux_slot #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_slot0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load0),
        .load_addr (in_addr),
        .load_data (in_data),
        .can_load  (can_load0),
        .valid     (out0_valid),
        .ready     (out0_ready),
        .addr      (out0_addr),
`ifdef WB_DEMUX_STATS_EN
        .count     (count0),
`endif
        .data      (out0_data)
    );

    wb_demux_slot #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_slot1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load1),
        .load_addr (in_addr),
        .load_data (in_data),
        .can_load  (can_load1),
        .valid     (out1_valid),
        .ready     (out1_ready),
        .addr      (out1_addr),
`ifdef WB_DEMUX_STATS_EN
        .count     (count1),
`endif
        .data      (out1_data)
    );

endmodule

// File: tb/tb_wb_demux_1_2.sv
// Scoreboard bench for wb_demux_1_2: directed writes, per-branch expected queues.
module tb_wb_demux_1_2;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready, in_select;
    logic [AW-1:0] in_addr;
    logic [DW-1:0] in_data;
    logic          out0_valid, out0_ready, out1_valid, out1_ready;
    logic [AW-1:0] out0_addr, out1_addr;
    logic [DW-1:0] out0_data, out1_data;
`ifdef WB_DEMUX_STATS_EN
    logic [15:0]   count0, count1;
`endif

    int total = 0;
    int bad   = 0;
    logic [AW+DW-1:0] exp0[$];
    logic [AW+DW-1:0] exp1[$];

    always #5 clk = ~clk;

    wb_demux_1_2 #(
        .DATA_W (DW),
        .ADDR_W (AW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_select  (in_select),
        .in_addr    (in_addr),
        .in_data    (in_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_addr  (out0_addr),
        .out0_data  (out0_data),
`ifdef WB_DEMUX_STATS_EN
        .count0     (count0),
        .count1     (count1),
`endif
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_addr  (out1_addr),
        .out1_data  (out1_data)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: event occurred, not expected", name);
    endtask

    // Monitor: every output handshake must match the oldest expected entry of its branch.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (out0_valid && out0_ready) begin
                if (exp0.size() == 0) fail_now("out0_unexpected");
                else check("out0_xfer", {out0_addr, out0_data}, exp0.pop_front());
            end
            if (out1_valid && out1_ready) begin
                if (exp1.size() == 0) fail_now("out1_unexpected");
                else check("out1_xfer", {out1_addr, out1_data}, exp1.pop_front());
            end
        end
    end

    task automatic drive(input logic sel, input logic [AW-1:0] a, input logic [DW-1:0] d);
        in_valid  = 1'b1;
        in_select = sel;
        in_addr   = a;
        in_data   = d;
    endtask

    // Waits for in_ready (bounded), records the expected output, ends at posedge+1.
    task automatic wait_accept(input int max, output int waited);
        waited = 0;
        @(negedge clk);
        while (!in_ready && waited < max) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) begin
            fail_now("accept_timeout");
        end else if (!(in_select == 1'b0 && in_addr == '0)) begin
            if (in_select) exp1.push_back({in_addr, in_data});
            else           exp0.push_back({in_addr, in_data});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst_n = 1'b0; in_valid = 1'b0; in_select = 1'b0; in_addr = '0; in_data = '0;
        out0_ready = 1'b0; out1_ready = 1'b0;
        #1;
        check("rst_v0", out0_valid, 0);
        check("rst_v1", out1_valid, 0);
        check("rst_a0", out0_addr, 0);
        check("rst_d1", out1_data, 0);
`ifdef WB_DEMUX_STATS_EN
        check("rst_c0", count0, 0);
        check("rst_c1", count1, 0);
`endif
        #20;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Branch steering
        out1_ready = 1'b1;
        drive(1'b1, 5'd3, 32'hDEADBEEF);
        wait_accept(5, w);
        check("steer_v1", out1_valid, 1);
        check("steer_v0", out0_valid, 0);
        check("steer_a1", out1_addr, 3);
        check("steer_d1", out1_data, 32'hDEADBEEF);
        @(posedge clk); #1;
        check("steer_drained", out1_valid, 0);

        // Back-pressure on branch 0
        out0_ready = 1'b0;
        drive(1'b0, 5'd4, 32'h4444_0004);
        wait_accept(5, w);
        drive(1'b0, 5'd5, 32'h5555_0005);
        repeat (2) begin
            @(negedge clk);
            check("bp_stall", in_ready, 0);
            check("bp_hold", out0_addr, 4);
            @(posedge clk); #1;
        end
        out0_ready = 1'b1;
        wait_accept(1, w);
        check("bp_passthru_wait", w, 0);
        check("bp_next_v", out0_valid, 1);
        check("bp_next_a", out0_addr, 5);
        @(posedge clk); #1;
        check("bp_empty", out0_valid, 0);

        // Independence: slot 0 stalled while branch 1 flows
        out0_ready = 1'b0;
        drive(1'b0, 5'd9, 32'h99);
        wait_accept(5, w);
        drive(1'b1, 5'd7, 32'h77);
        wait_accept(5, w);
        check("indep_wait", w, 0);
        check("indep_v1", out1_valid, 1);
        check("indep_a1", out1_addr, 7);
        check("indep_a0", out0_addr, 9);
        check("indep_d0", out0_data, 32'h99);
        @(posedge clk); #1;
        check("indep_drained1", out1_valid, 0);
        check("indep_v0", out0_valid, 1);

        // Zero-register drop while slot 0 is full and stalled
        drive(1'b0, 5'd0, 32'h1);
        wait_accept(5, w);
        check("drop_wait", w, 0);
        check("drop_v0", out0_valid, 1);
        check("drop_a0", out0_addr, 9);
        check("drop_d0", out0_data, 32'h99);
        out0_ready = 1'b1;
        @(posedge clk); #1;
        check("drop_drained", out0_valid, 0);
        @(posedge clk); #1;
        check("drop_no_extra", out0_valid, 0);

        // Back-to-back throughput on branch 1
        out1_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, AW'(10 + i), DW'(32'hA0 + i));
            @(negedge clk);
            check("tput_ready", in_ready, 1);
            exp1.push_back({in_addr, in_data});
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("tput_drained", out1_valid, 0);
`ifdef WB_DEMUX_STATS_EN
        check("cnt0_mid", count0, 3);
        check("cnt1_mid", count1, 6);
`endif

        // Reset mid-traffic with both slots full
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        drive(1'b0, 5'd2, 32'h22);
        wait_accept(5, w);
        drive(1'b1, 5'd3, 32'h33);
        wait_accept(5, w);
        check("pre_rst_v0", out0_valid, 1);
        check("pre_rst_v1", out1_valid, 1);
        @(negedge clk); #2;
        rst_n = 1'b0;
        exp0.delete();
        exp1.delete();
        #1;
        check("mrst_v0", out0_valid, 0);
        check("mrst_v1", out1_valid, 0);
        check("mrst_d0", out0_data, 0);
        check("mrst_d1", out1_data, 0);
`ifdef WB_DEMUX_STATS_EN
        check("mrst_c0", count0, 0);
        check("mrst_c1", count1, 0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_v0", out0_valid, 0);

`ifdef WB_DEMUX_STATS_EN
        // Saturation of count1
        out1_ready = 1'b1;
        drive(1'b1, 5'd1, 32'hC0FFEE);
        for (int i = 0; i < 70000; i++) begin
            @(negedge clk);
            if (in_ready) exp1.push_back({in_addr, in_data});
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("sat_c1", count1, 16'hFFFF);
        check("sat_c0", count0, 0);
`endif

        check("sb0_empty", exp0.size(), 0);
        check("sb1_empty", exp1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
